// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle sequencer for the SDIV (ALUControl 3'b101) and UDIV
// (ALUControl 3'b110) operations. It accepts a divide request from the
// execute stage and holds the pipeline with stall. It then runs a radix-2
// restoring divider, one quotient bit per cycle, and presents quotient and
// remainder with a single-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        divide request from the execute stage
//   ALUControl   op code; 3'b101 = SDIV, 3'b110 = UDIV, other codes ignored
//   a, b         dividend, divisor
//   stall        holds the pipeline while a divide is pending
//   busy         sequencer is not idle
//   done         one-cycle pulse; quotient/remainder valid this cycle
//   quotient     registered quotient (truncated toward zero)
//   remainder    registered remainder (sign of the dividend)
//   div_by_zero  registered; set together with done when b == 0
// ---------------------------------------------------------------------------
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]      OP_SDIV  = 3'b101;
    localparam logic [2:0]      OP_UDIV  = 3'b110;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1'b1);
    endfunction

    // Magnitude of v when interpreted as signed; passes v through otherwise.
    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? twos_neg(v) : v;
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   dvd_r;       // dividend, shifted out MSB first
    logic [WIDTH-1:0]   dvs_r;       // divisor (magnitude after PREP)
    logic [WIDTH-1:0]   quo_r;       // quotient being assembled
    logic [WIDTH-1:0]   prem_r;      // partial remainder; always below the divisor
    logic               signed_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [CNT_W-1:0]   count_r;
    logic               hold_r;      // registered part of stall (PREP/ITER/FIX)
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;

    logic               accept_s;
    logic [WIDTH:0]     shifted_s;   // partial remainder with next dividend bit
    logic [WIDTH:0]     trial_s;     // trial subtraction; MSB set means negative

    // Accept decode and one restoring-division trial step.
    always_comb begin
        accept_s  = 1'b0;
        shifted_s = {prem_r, dvd_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if ((state_r == S_IDLE) && start &&
            ((ALUControl == OP_SDIV) || (ALUControl == OP_UDIV))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            prem_r      <= {WIDTH{1'b0}};
            signed_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            hold_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        dvd_r    <= a;
                        dvs_r    <= b;
                        signed_r <= (ALUControl == OP_SDIV);
                        hold_r   <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= S_PREP;
                    end else begin
                        hold_r   <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (dvs_r == {WIDTH{1'b0}}) begin
                        quotient_r  <= {WIDTH{1'b0}};
                        remainder_r <= dvd_r;
                        dbz_r       <= 1'b1;
                        done_r      <= 1'b1;
                        hold_r      <= 1'b0;
                        state_r     <= S_DONE;
                    end else begin
                        dvd_r   <= magnitude(dvd_r, signed_r);
                        dvs_r   <= magnitude(dvs_r, signed_r);
                        neg_q_r <= signed_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
                        neg_r_r <= signed_r & dvd_r[WIDTH-1];
                        prem_r  <= {WIDTH{1'b0}};
                        quo_r   <= {WIDTH{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                        state_r <= S_ITER;
                    end
                end
                S_ITER: begin
                    dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    if (!trial_s[WIDTH]) begin
                        prem_r <= trial_s[WIDTH-1:0];
                        quo_r  <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        prem_r <= shifted_s[WIDTH-1:0];
                        quo_r  <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    count_r <= count_r + CNT_W'(1'b1);
                    if (count_r == LAST_CNT) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_FIX: begin
                    quotient_r  <= neg_q_r ? twos_neg(quo_r) : quo_r;
                    remainder_r <= neg_r_r ? twos_neg(prem_r) : prem_r;
                    dbz_r       <= 1'b0;
                    done_r      <= 1'b1;
                    hold_r      <= 1'b0;
                    state_r     <= S_DONE;
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    hold_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    hold_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // The accept term must stall the requesting instruction in its own cycle.
    assign stall       = accept_s | hold_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
